// File: rtl/udp_frame_tx.sv
// GMII UDP/IPv4 frame transmitter. Payload bytes are buffered first. A frame request then
// emits preamble, Ethernet/IP/UDP headers, payload, pad and CRC-32 FCS, followed by a forced IFG.
module udp_frame_tx #(
    parameter int         FIFO_DEPTH = 2048,
    parameter int         IFG_CYCLES = 12,
    parameter logic [7:0] IP_TTL     = 8'd64
) (
    input  logic                          gmii_tx_clk,
    input  logic                          rst_n,
    input  logic                          wrreq,
    input  logic [7:0]                    wrdata,
    output logic                          wr_full,
    output logic [$clog2(FIFO_DEPTH):0]   wrusedw,
    input  logic                          tx_start,
    input  logic [15:0]                   tx_len,
    input  logic [47:0]                   des_mac,
    input  logic [47:0]                   src_mac,
    input  logic [31:0]                   des_ip,
    input  logic [31:0]                   src_ip,
    input  logic [15:0]                   des_port,
    input  logic [15:0]                   src_port,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          tx_err,
    output logic [7:0]                    gmii_txd,
    output logic                          gmii_txen,
    output logic [3:0]                    dbg_state
);

    localparam int              AW          = $clog2(FIFO_DEPTH);
    localparam int              CW          = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT    = CW'(FIFO_DEPTH);
    localparam logic [15:0]     MAX_LEN     = 16'd1472;
    localparam logic [15:0]     MIN_PAYLOAD = 16'd18;
    localparam logic [15:0]     IFG_LAST    = 16'(IFG_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PREAMBLE = 4'd1,
        S_ETH_HDR  = 4'd2,
        S_IP_HDR   = 4'd3,
        S_UDP_HDR  = 4'd4,
        S_PAYLOAD  = 4'd5,
        S_PAD      = 4'd6,
        S_FCS      = 4'd7,
        S_IFG      = 4'd8
    } state_t;

    state_t state, state_n;
    logic [15:0] cnt, cnt_n;

    // Handshakes: a byte is stored on any clock with wrreq=1 and wr_full=0, otherwise it is lost.
    // tx_start is a one-cycle request taken only in IDLE with a legal, fully buffered length;
    // a request that is not taken is answered by a tx_err pulse on the following cycle.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [CW-1:0] count;
    logic [7:0]    head;
    logic          wr_en, pop;

    assign wr_full     = (count == FULL_CNT);
    assign wrusedw     = count;
    assign wr_en       = wrreq && !wr_full;
    assign rd_ptr_next = rd_ptr + AW'(pop);

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_next;
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // head always holds the byte at the read pointer, so a pop never leaves a bubble.
    always_ff @(posedge gmii_tx_clk) begin
        if (wr_en) mem[wr_ptr] <= wrdata;
        head <= mem[rd_ptr_next];
    end

    logic [15:0] len_q, des_port_q, src_port_q, ip_id, ip_csum, ip_total, udp_len, pad_last;
    logic [47:0] des_mac_q, src_mac_q;
    logic [31:0] des_ip_q, src_ip_q, crc, crc_inv;
    logic [19:0] ip_sum;
    logic [16:0] ip_fold1;
    logic [15:0] ip_fold2;
    logic        accept, len_ok, fifo_ok, crc_en;
    logic [7:0]  txd, eth_byte, ip_byte, udp_byte, fcs_byte;

    assign len_ok   = (tx_len != 16'd0) && (tx_len <= MAX_LEN);
    assign fifo_ok  = (16'(count) >= tx_len);
    assign accept   = (state == S_IDLE) && tx_start && len_ok && fifo_ok;
    assign ip_total = len_q + 16'd28;
    assign udp_len  = len_q + 16'd8;
    assign pad_last = MIN_PAYLOAD - 16'd1 - len_q;
    assign crc_inv  = ~crc;

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Header checksum over every word except the checksum itself; two folds absorb all carries.
    always_comb begin
        ip_sum   = 20'h04500 + {4'h0, ip_total} + {4'h0, ip_id} + 20'h04000
                 + {4'h0, IP_TTL, 8'h11}
                 + {4'h0, src_ip_q[31:16]} + {4'h0, src_ip_q[15:0]}
                 + {4'h0, des_ip_q[31:16]} + {4'h0, des_ip_q[15:0]};
        ip_fold1 = {1'b0, ip_sum[15:0]} + {13'h0, ip_sum[19:16]};
        ip_fold2 = ip_fold1[15:0] + {15'h0, ip_fold1[16]};
    end

    always_comb begin
        eth_byte = 8'h00;
        case (cnt[3:0])
            4'd0:    eth_byte = des_mac_q[47:40];
            4'd1:    eth_byte = des_mac_q[39:32];
            4'd2:    eth_byte = des_mac_q[31:24];
            4'd3:    eth_byte = des_mac_q[23:16];
            4'd4:    eth_byte = des_mac_q[15:8];
            4'd5:    eth_byte = des_mac_q[7:0];
            4'd6:    eth_byte = src_mac_q[47:40];
            4'd7:    eth_byte = src_mac_q[39:32];
            4'd8:    eth_byte = src_mac_q[31:24];
            4'd9:    eth_byte = src_mac_q[23:16];
            4'd10:   eth_byte = src_mac_q[15:8];
            4'd11:   eth_byte = src_mac_q[7:0];
            4'd12:   eth_byte = 8'h08;
            default: eth_byte = 8'h00;
        endcase
    end

    always_comb begin
        ip_byte = 8'h00;
        case (cnt[4:0])
            5'd0:    ip_byte = 8'h45;
            5'd1:    ip_byte = 8'h00;
            5'd2:    ip_byte = ip_total[15:8];
            5'd3:    ip_byte = ip_total[7:0];
            5'd4:    ip_byte = ip_id[15:8];
            5'd5:    ip_byte = ip_id[7:0];
            5'd6:    ip_byte = 8'h40;
            5'd7:    ip_byte = 8'h00;
            5'd8:    ip_byte = IP_TTL;
            5'd9:    ip_byte = 8'h11;
            5'd10:   ip_byte = ip_csum[15:8];
            5'd11:   ip_byte = ip_csum[7:0];
            5'd12:   ip_byte = src_ip_q[31:24];
            5'd13:   ip_byte = src_ip_q[23:16];
            5'd14:   ip_byte = src_ip_q[15:8];
            5'd15:   ip_byte = src_ip_q[7:0];
            5'd16:   ip_byte = des_ip_q[31:24];
            5'd17:   ip_byte = des_ip_q[23:16];
            5'd18:   ip_byte = des_ip_q[15:8];
            5'd19:   ip_byte = des_ip_q[7:0];
            default: ip_byte = 8'h00;
        endcase
    end

    always_comb begin
        udp_byte = 8'h00;
        case (cnt[2:0])
            3'd0:    udp_byte = src_port_q[15:8];
            3'd1:    udp_byte = src_port_q[7:0];
            3'd2:    udp_byte = des_port_q[15:8];
            3'd3:    udp_byte = des_port_q[7:0];
            3'd4:    udp_byte = udp_len[15:8];
            3'd5:    udp_byte = udp_len[7:0];
            default: udp_byte = 8'h00;
        endcase
    end

    always_comb begin
        fcs_byte = 8'h00;
        case (cnt[1:0])
            2'd0:    fcs_byte = crc_inv[7:0];
            2'd1:    fcs_byte = crc_inv[15:8];
            2'd2:    fcs_byte = crc_inv[23:16];
            default: fcs_byte = crc_inv[31:24];
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 16'd1;
        txd     = 8'h00;
        pop     = 1'b0;
        crc_en  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = 16'd0;
                if (accept) state_n = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                txd = (cnt == 16'd7) ? 8'hD5 : 8'h55;
                if (cnt == 16'd7) begin
                    state_n = S_ETH_HDR;
                    cnt_n   = 16'd0;
                end
            end
            S_ETH_HDR: begin
                txd    = eth_byte;
                crc_en = 1'b1;
                if (cnt == 16'd13) begin
                    state_n = S_IP_HDR;
                    cnt_n   = 16'd0;
                end
            end
            S_IP_HDR: begin
                txd    = ip_byte;
                crc_en = 1'b1;
                if (cnt == 16'd19) begin
                    state_n = S_UDP_HDR;
                    cnt_n   = 16'd0;
                end
            end
            S_UDP_HDR: begin
                txd    = udp_byte;
                crc_en = 1'b1;
                if (cnt == 16'd7) begin
                    state_n = S_PAYLOAD;
                    cnt_n   = 16'd0;
                end
            end
            S_PAYLOAD: begin
                txd    = head;
                pop    = 1'b1;
                crc_en = 1'b1;
                if (cnt == len_q - 16'd1) begin
                    state_n = (len_q < MIN_PAYLOAD) ? S_PAD : S_FCS;
                    cnt_n   = 16'd0;
                end
            end
            S_PAD: begin
                crc_en = 1'b1;
                if (cnt == pad_last) begin
                    state_n = S_FCS;
                    cnt_n   = 16'd0;
                end
            end
            S_FCS: begin
                txd = fcs_byte;
                if (cnt == 16'd3) begin
                    state_n = S_IFG;
                    cnt_n   = 16'd0;
                end
            end
            S_IFG: begin
                if (cnt == IFG_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = 16'd0;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 16'd0;
            len_q      <= 16'd0;
            des_mac_q  <= 48'd0;
            src_mac_q  <= 48'd0;
            des_ip_q   <= 32'd0;
            src_ip_q   <= 32'd0;
            des_port_q <= 16'd0;
            src_port_q <= 16'd0;
            ip_id      <= 16'd0;
            ip_csum    <= 16'd0;
            crc        <= 32'hFFFF_FFFF;
            tx_err     <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            tx_err <= tx_start && !accept;
            if (accept) begin
                len_q      <= tx_len;
                des_mac_q  <= des_mac;
                src_mac_q  <= src_mac;
                des_ip_q   <= des_ip;
                src_ip_q   <= src_ip;
                des_port_q <= des_port;
                src_port_q <= src_port;
            end
            if (state == S_PREAMBLE) ip_csum <= ~ip_fold2;
            if (tx_done) ip_id <= ip_id + 16'd1;
            if (state == S_IDLE) begin
                crc <= 32'hFFFF_FFFF;
            end else if (crc_en) begin
                crc <= crc_step(crc, txd);
            end
        end
    end

    assign gmii_txd  = txd;
    assign gmii_txen = (state != S_IDLE) && (state != S_IFG);
    assign tx_busy   = (state != S_IDLE);
    assign tx_done   = (state == S_FCS) && (cnt == 16'd3);
    assign dbg_state = state;

endmodule

// File: tb/tb_udp_frame_tx.sv
// Directed bench for udp_frame_tx: captures whole GMII frames and checks them against
// hand-derived header bytes, checksums, lengths and the CRC-32 residue.
module tb_udp_frame_tx;

    localparam int FIFO_DEPTH = 64;
    localparam int IFG_CYCLES = 12;
    localparam int UW         = $clog2(FIFO_DEPTH) + 1;

    localparam logic [47:0] DES_MAC  = 48'h000A_3501_FEC0;
    localparam logic [47:0] SRC_MAC  = 48'hC85B_76DD_0B38;
    localparam logic [31:0] DES_IP   = 32'hC0A8_0002;
    localparam logic [31:0] SRC_IP   = 32'hC0A8_0003;
    localparam logic [15:0] DES_PORT = 16'd5000;
    localparam logic [15:0] SRC_PORT = 16'd6102;

    logic          gmii_tx_clk = 1'b0;
    logic          rst_n       = 1'b0;
    logic          wrreq       = 1'b0;
    logic [7:0]    wrdata      = 8'h00;
    logic          wr_full;
    logic [UW-1:0] wrusedw;
    logic          tx_start    = 1'b0;
    logic [15:0]   tx_len      = 16'd0;
    logic [47:0]   des_mac     = DES_MAC;
    logic [47:0]   src_mac     = SRC_MAC;
    logic [31:0]   des_ip      = DES_IP;
    logic [31:0]   src_ip      = SRC_IP;
    logic [15:0]   des_port    = DES_PORT;
    logic [15:0]   src_port    = SRC_PORT;
    logic          tx_busy, tx_done, tx_err;
    logic [7:0]    gmii_txd;
    logic          gmii_txen;
    logic [3:0]    dbg_state;

    udp_frame_tx #(.FIFO_DEPTH(FIFO_DEPTH), .IFG_CYCLES(IFG_CYCLES), .IP_TTL(8'd64)) dut (
        .gmii_tx_clk(gmii_tx_clk), .rst_n(rst_n),
        .wrreq(wrreq), .wrdata(wrdata), .wr_full(wr_full), .wrusedw(wrusedw),
        .tx_start(tx_start), .tx_len(tx_len),
        .des_mac(des_mac), .src_mac(src_mac), .des_ip(des_ip), .src_ip(src_ip),
        .des_port(des_port), .src_port(src_port),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
        .gmii_txd(gmii_txd), .gmii_txen(gmii_txen), .dbg_state(dbg_state)
    );

    always #4 gmii_tx_clk = ~gmii_tx_clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] frame[$];
    logic [7:0] exp_q[$];
    logic [7:0] payload[$];
    int done_idx, done_hits, err_hits, timeout;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wrreq  = 1'b1;
        wrdata = b;
        @(negedge gmii_tx_clk);
        wrreq  = 1'b0;
    endtask

    task automatic write_payload();
        foreach (payload[i]) write_byte(payload[i]);
    endtask

    task automatic set_hello();
        string s;
        s = "Hello, welcome to FPGA!";
        payload.delete();
        for (int i = 0; i < s.len(); i++) payload.push_back(s[i]);
    endtask

    task automatic start_frame(input logic [15:0] len);
        tx_len   = len;
        tx_start = 1'b1;
        @(negedge gmii_tx_clk);
        tx_start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge gmii_tx_clk);
        rst_n = 1'b1;
        @(negedge gmii_tx_clk);
    endtask

    // Collects bytes while txen is high; optionally fires a stray tx_start and/or writes bytes.
    task automatic capture(input int inject_at, input int write_cycles);
        int guard;
        guard = 0;
        frame.delete();
        done_idx = -1; done_hits = 0; err_hits = 0; timeout = 0;
        while (gmii_txen === 1'b1 && guard < 4000) begin
            frame.push_back(gmii_txd);
            if (tx_done === 1'b1) begin
                done_idx = frame.size();
                done_hits++;
            end
            if (tx_err === 1'b1) err_hits++;
            tx_start = (frame.size() - 1 == inject_at);
            wrreq    = (frame.size() <= write_cycles);
            wrdata   = 8'h5A;
            @(negedge gmii_tx_clk);
            guard++;
        end
        tx_start = 1'b0;
        wrreq    = 1'b0;
        if (guard >= 4000) timeout = 1;
    endtask

    function automatic logic [15:0] header_sum();
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < 10; k++) s += {16'h0, frame[22 + 2 * k], frame[23 + 2 * k]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return s[15:0];
    endfunction

    function automatic logic [31:0] crc_residue();
        logic [31:0] c, r;
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < frame.size(); i++) begin
            c ^= {24'h0, frame[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        for (int b = 0; b < 32; b++) r[b] = c[31 - b];
        return r;
    endfunction

    task automatic verify_frame(input string tag, input logic [15:0] len, input logic [15:0] id,
                                input logic [15:0] csum, input int exp_total, input int exp_err);
        logic [15:0] total, ulen;
        total = len + 16'd28;
        ulen  = len + 16'd8;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) exp_q.push_back(DES_MAC[47 - 8 * i -: 8]);
        for (int i = 0; i < 6; i++) exp_q.push_back(SRC_MAC[47 - 8 * i -: 8]);
        exp_q.push_back(8'h08); exp_q.push_back(8'h00);
        exp_q.push_back(8'h45); exp_q.push_back(8'h00);
        exp_q.push_back(total[15:8]); exp_q.push_back(total[7:0]);
        exp_q.push_back(id[15:8]); exp_q.push_back(id[7:0]);
        exp_q.push_back(8'h40); exp_q.push_back(8'h00);
        exp_q.push_back(8'h40); exp_q.push_back(8'h11);
        exp_q.push_back(csum[15:8]); exp_q.push_back(csum[7:0]);
        for (int i = 0; i < 4; i++) exp_q.push_back(SRC_IP[31 - 8 * i -: 8]);
        for (int i = 0; i < 4; i++) exp_q.push_back(DES_IP[31 - 8 * i -: 8]);
        exp_q.push_back(SRC_PORT[15:8]); exp_q.push_back(SRC_PORT[7:0]);
        exp_q.push_back(DES_PORT[15:8]); exp_q.push_back(DES_PORT[7:0]);
        exp_q.push_back(ulen[15:8]); exp_q.push_back(ulen[7:0]);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        foreach (payload[i]) exp_q.push_back(payload[i]);
        while (exp_q.size() < 68) exp_q.push_back(8'h00);

        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_txen_cycles"}, frame.size(), exp_total);
        for (int i = 0; i < exp_q.size() && i < frame.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), frame[i], exp_q[i]);
        if (frame.size() >= 50) check({tag, "_hdr_sum"}, header_sum(), 16'hFFFF);
        check({tag, "_crc_residue"}, crc_residue(), 32'hC704DD7B);
        check({tag, "_done_cycle"}, done_idx, exp_total);
        check({tag, "_done_pulses"}, done_hits, 1);
        check({tag, "_err_pulses"}, err_hits, exp_err);
    endtask

    initial begin
        int gap, ifg_busy, txd_bad, guard;

        // Reset values while rst_n is held low.
        repeat (3) @(negedge gmii_tx_clk);
        check("rst_txen", gmii_txen, 1'b0);
        check("rst_txd", gmii_txd, 8'h00);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_err", tx_err, 1'b0);
        check("rst_wrusedw", wrusedw, 0);
        check("rst_full", wr_full, 1'b0);
        rst_n = 1'b1;
        @(negedge gmii_tx_clk);

        // Rejections: too few bytes buffered, zero length, oversize length.
        for (int i = 0; i < 5; i++) write_byte(8'(i));
        check("rej_wrusedw_before", wrusedw, 5);
        start_frame(16'd10);
        check("rej_short_err", tx_err, 1'b1);
        check("rej_short_txen", gmii_txen, 1'b0);
        check("rej_short_busy", tx_busy, 1'b0);
        @(negedge gmii_tx_clk);
        check("rej_err_pulse_end", tx_err, 1'b0);
        check("rej_txen_later", gmii_txen, 1'b0);
        check("rej_wrusedw_after", wrusedw, 5);
        start_frame(16'd0);
        check("rej_len0_err", tx_err, 1'b1);
        @(negedge gmii_tx_clk);
        start_frame(16'd1473);
        check("rej_len1473_err", tx_err, 1'b1);
        @(negedge gmii_tx_clk);
        check("rej_len1473_txen", gmii_txen, 1'b0);
        do_reset();
        check("reset_clears_fifo", wrusedw, 0);

        // Frame A (23 bytes) then frame B (4 bytes) back to back.
        set_hello();
        write_payload();
        for (int i = 0; i < 4; i++) write_byte(8'hC0 + 8'(i));
        check("ab_wrusedw", wrusedw, 27);
        start_frame(16'd23);
        check("a_txen_next", gmii_txen, 1'b1);
        check("a_busy_next", tx_busy, 1'b1);
        capture(30, 0);
        verify_frame("a", 16'd23, 16'h0000, 16'hB964, 77, 1);
        check("a_ip_len", {frame[24], frame[25]}, 16'h0033);
        check("a_udp_len", {frame[46], frame[47]}, 16'h001F);
        check("a_wrusedw_after", wrusedw, 4);

        gap = 0; ifg_busy = 0; txd_bad = 0; guard = 0;
        while (tx_busy === 1'b1 && guard < 200) begin
            if (gmii_txen === 1'b0) gap++;
            if (gmii_txd !== 8'h00) txd_bad++;
            ifg_busy++;
            guard++;
            @(negedge gmii_tx_clk);
        end
        if (gmii_txen === 1'b0) gap++;
        check("ifg_busy_cycles", ifg_busy, IFG_CYCLES);
        check("ifg_gap_min", (gap >= IFG_CYCLES), 1'b1);
        check("ifg_txd_zero", txd_bad, 0);

        payload.delete();
        for (int i = 0; i < 4; i++) payload.push_back(8'hC0 + 8'(i));
        start_frame(16'd4);
        check("b_txen_next", gmii_txen, 1'b1);
        capture(-1, 60);
        verify_frame("b", 16'd4, 16'h0001, 16'hB976, 72, 0);
        check("b_udp_len", {frame[46], frame[47]}, 16'h000C);
        check("b_wrusedw_write_pop", wrusedw, 60);
        check("b_not_full", wr_full, 1'b0);
        do_reset();

        // Reset in the middle of the payload, then a clean resend.
        set_hello();
        write_payload();
        start_frame(16'd23);
        repeat (55) @(negedge gmii_tx_clk);
        check("mid_txd_payload5", gmii_txd, 8'h2C);
        check("mid_wrusedw", wrusedw, 18);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txen", gmii_txen, 1'b0);
        check("mid_rst_txd", gmii_txd, 8'h00);
        check("mid_rst_wrusedw", wrusedw, 0);
        check("mid_rst_busy", tx_busy, 1'b0);
        @(negedge gmii_tx_clk);
        rst_n = 1'b1;
        @(negedge gmii_tx_clk);
        write_payload();
        start_frame(16'd23);
        capture(-1, 0);
        verify_frame("c", 16'd23, 16'h0000, 16'hB964, 77, 0);
        repeat (IFG_CYCLES + 2) @(negedge gmii_tx_clk);

        // Overfill: the three bytes beyond capacity must be dropped.
        for (int i = 0; i < FIFO_DEPTH + 3; i++) write_byte(8'(i));
        check("full_flag", wr_full, 1'b1);
        check("full_wrusedw", wrusedw, FIFO_DEPTH);
        payload.delete();
        for (int i = 0; i < FIFO_DEPTH; i++) payload.push_back(8'(i));
        start_frame(16'(FIFO_DEPTH));
        check("d_txen_next", gmii_txen, 1'b1);
        capture(-1, 0);
        verify_frame("d", 16'd64, 16'h0001, 16'hB93A, 118, 0);
        check("d_wrusedw_empty", wrusedw, 0);
        check("d_not_full", wr_full, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
